sha256_block_engine: RTL and testbench
======================================

SHA256_BLOCK_ENGINE -- requirements
Module: sha256_block_engine

Interface
REQ-001 The block SHALL have no parameters; all sizes are fixed by SHA-256.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to compress one block; sampled only while ready=1.
REQ-005 block_in  input  512  message block; W0 = [511:480] ... W15 = [31:0].
REQ-006 hash_in  input  256  chaining value; H0/a = [255:224] ... H7/h = [31:0].
REQ-007 ready  output  1  engine idle; start accepted this cycle.
REQ-008 busy  output  1  compression in progress.
REQ-009 done  output  1  one-cycle pulse; hash_out valid.
REQ-010 hash_out  output  256  chaining result, same word order as hash_in; holds until the next done.

Function
REQ-011 The FSM SHALL have states IDLE, ROUND and FINAL; ready = (state==IDLE); busy = (state!=IDLE).
REQ-012 At the edge E with start=1 and ready=1, the block SHALL:
- capture hash_in into the a..h working registers and a separate H copy;
- load the 16-word W window from block_in;
- clear the round counter t;
- go to ROUND.
REQ-013 In ROUND the block SHALL perform one round per edge, t=0..63, on edges E+1..E+64.
REQ-014 Each round SHALL apply the standard update using the existing sig_0, sig_1, Sig0, Sig1, ch and maj functions:
- T1 = h + Sig1(e) + ch(e,f,g) + K[t] + W[t];
- T2 = Sig0(a) + maj(a,b,c);
- all additions modulo 2^32.
REQ-015 W[t] SHALL be window word 0. Each round SHALL shift the window and append W[t+16] = sig_1(W[t+14]) + W[t+9] + sig_0(W[t+1]) + W[t], modulo 2^32.
REQ-016 The round counter SHALL be 6 bits; at t=63 the FSM SHALL go to FINAL without relying on counter wrap.
REQ-017 At edge E+65 (FINAL), the block SHALL:
- set hash_out word i = H[i] + working word i, modulo 2^32;
- assert done for exactly one cycle;
- return to IDLE.
Latency from the start edge to the done-high cycle is 65 edges.
REQ-018 start while busy=1 SHALL be ignored, with no effect on the working registers or on hash_out.
REQ-019 Changes to block_in and hash_in after the acceptance edge SHALL have no effect on the result.
REQ-020 In the cycle where done=1, ready=1. A start in that cycle SHALL be accepted, giving back-to-back operation with no idle gap.
REQ-021 done SHALL never be asserted without a preceding accepted start.

Reset
REQ-022 While rst_n=0 the block SHALL hold:
- state=IDLE, t=0;
- done=0, busy=0, ready=1;
- hash_out=0;
- working registers and W window = 0.
REQ-023 Reset asserted mid-operation SHALL abort immediately: no done pulse, hash_out=0. After reset release the first start is accepted normally.

Structure
REQ-024 A shared package sha256_pkg SHALL hold:
- the 64-entry K constant array;
- the FSM state enum;
- the SHA-256 initial hash value constant (IV).
REQ-025 One combinational sub-module, sha256_round, SHALL compute the next a..h from a..h, K[t] and W[t]. The schedule expansion stays in sha256_block_engine.

Verification
REQ-026 "abc" vector: block_in = 61626380 followed by 0x00 to 0x...18, hash_in = IV -> done at edge E+65, hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-027 Empty-message vector: block_in = 80000000 then zeros, hash_in = IV -> hash_out = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-028 Back-to-back: start held high through the first done cycle, second block = "abc" -> second done exactly 66 edges after the first, with both digests correct.
REQ-029 start pulsed at round t=10 with different block_in -> ignored, and the first digest is unchanged.
REQ-030 rst_n low at round t=30 -> done never pulses, hash_out=0, ready=1. A following "abc" start produces the correct digest.
REQ-031 block_in and hash_in randomized every cycle after acceptance -> digest equals the value computed from the inputs captured at the acceptance edge.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type, working-set struct and round helpers.
// Latency/backpressure: n/a (declarations only).
package sha256_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_e;

    // Word a sits in the top 32 bits, matching the hash_in/hash_out word order.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } work_t;

    localparam logic [255:0] IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig_0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig_1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] Sig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] Sig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_block_engine_if.sv
// Block-level request/result bundle for sha256_block_engine; master drives start and data.
// Latency/backpressure: n/a; start is only honoured while ready is high.
interface sha256_block_engine_if;
    logic         start;
    logic [511:0] block_in;
    logic [255:0] hash_in;
    logic         ready;
    logic         busy;
    logic         done;
    logic [255:0] hash_out;

    modport master (output start, block_in, hash_in,
                    input  ready, busy, done, hash_out);
    modport slave  (input  start, block_in, hash_in,
                    output ready, busy, done, hash_out);
endinterface

// File: rtl/sha256_round.sv
// One SHA-256 round: next a..h from current a..h, K[t] and W[t].
// Latency: combinational; backpressure: none, the caller chooses when to register.
module sha256_round
    import sha256_pkg::*;
(
    input  work_t       cur,
    input  logic [31:0] k_t,
    input  logic [31:0] w_t,
    output work_t       nxt
);

    logic [31:0] t1;
    logic [31:0] t2;

    always_comb begin
        t1    = cur.h + Sig1(cur.e) + ch(cur.e, cur.f, cur.g) + k_t + w_t;
        t2    = Sig0(cur.a) + maj(cur.a, cur.b, cur.c);
        nxt.a = t1 + t2;
        nxt.b = cur.a;
        nxt.c = cur.b;
        nxt.d = cur.c;
        nxt.e = cur.d + t1;
        nxt.f = cur.e;
        nxt.g = cur.f;
        nxt.h = cur.g;
    end

endmodule

// File: rtl/sha256_block_engine.sv
// Iterative SHA-256 compression of one 512-bit block; done pulses 65 edges after the start edge.
// Backpressure: start is ignored while busy; ready is already high in the done cycle.
module sha256_block_engine
    import sha256_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    sha256_block_engine_if.slave   bus
);

    state_e       state_q, state_d;
    logic [5:0]   t_q, t_d;
    work_t        work_q, work_d;
    logic [255:0] hinit_q, hinit_d;
    logic [31:0]  w_q [16];
    logic [31:0]  w_d [16];
    logic [255:0] hash_out_q, hash_out_d;
    logic         done_q, done_d;

    work_t        round_nxt;
    logic [31:0]  w_new;

    sha256_round u_round (
        .cur (work_q),
        .k_t (K[t_q]),
        .w_t (w_q[0]),
        .nxt (round_nxt)
    );

    // Window slot 0 is W[t]; the new word W[t+16] enters at slot 15.
    assign w_new = sig_1(w_q[14]) + w_q[9] + sig_0(w_q[1]) + w_q[0];

    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        work_d     = work_q;
        hinit_d    = hinit_q;
        w_d        = w_q;
        hash_out_d = hash_out_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    work_d  = work_t'(bus.hash_in);
                    hinit_d = bus.hash_in;
                    for (int i = 0; i < 16; i++) begin
                        w_d[i] = bus.block_in[511 - 32*i -: 32];
                    end
                    t_d     = 6'd0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                work_d = round_nxt;
                for (int i = 0; i < 15; i++) begin
                    w_d[i] = w_q[i + 1];
                end
                w_d[15] = w_new;
                // Leave on the explicit terminal count rather than on the 6-bit wrap.
                if (t_q == 6'd63) begin
                    state_d = FINAL;
                end else begin
                    t_d = t_q + 6'd1;
                end
            end
            FINAL: begin
                for (int i = 0; i < 8; i++) begin
                    hash_out_d[32*i +: 32] = hinit_q[32*i +: 32] + work_q[32*i +: 32];
                end
                done_d  = 1'b1;
                t_d     = 6'd0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            t_q        <= 6'd0;
            work_q     <= '0;
            hinit_q    <= '0;
            w_q        <= '{default: 32'h0};
            hash_out_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            work_q     <= work_d;
            hinit_q    <= hinit_d;
            w_q        <= w_d;
            hash_out_q <= hash_out_d;
            done_q     <= done_d;
        end
    end

    assign bus.ready    = (state_q == IDLE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.hash_out = hash_out_q;

endmodule

// File: tb/tb_sha256_block_engine.sv
// Self-checking bench for sha256_block_engine: vector table, scoreboard and corner sequences.
module tb_sha256_block_engine;
    import sha256_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sha256_block_engine_if bus ();

    sha256_block_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_seen = 0;
    logic scramble = 1'b0;

    typedef struct {
        logic [255:0] dig;
        int           edge_n;
    } exp_t;
    exp_t sb_q [$];
    exp_t sb_e;

    typedef struct {
        logic [511:0] blk;
        logic [255:0] hv;
        logic [255:0] dig;
    } vec_t;
    vec_t vecs [4];

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [255:0] DIG_ABC   =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIG_EMPTY =
        256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Straight-line reference: full 64-word schedule, then 64 rounds, then feed-forward.
    function automatic logic [255:0] ref_compress(input logic [511:0] blk, input logic [255:0] hv);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        for (int i = 0; i < 8; i++) v[i] = hv[255 - 32*i -: 32];
        for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[i] + w[i];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hv[255 - 32*i -: 32] + v[i];
        return r;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: push at the acceptance edge's preceding negedge, pop on done.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (bus.start && bus.ready)
                sb_q.push_back('{ref_compress(bus.block_in, bus.hash_in), cyc + 1});
            if (bus.done) begin
                done_seen++;
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d required no done", cyc);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("sb_digest", bus.hash_out, sb_e.dig);
                    check("sb_latency", 256'(cyc - sb_e.edge_n), 256'(65));
                end
            end
        end
    end

    always @(posedge clk) begin
        if (scramble) begin
            #1;
            bus.block_in = rand512();
            bus.hash_in  = rand256();
        end
    end

    task automatic launch(input logic [511:0] b, input logic [255:0] h);
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.block_in = b;
        bus.hash_in  = h;
        @(posedge clk); #1;
        bus.start    = 1'b0;
    endtask

    task automatic wait_done(output int at_cyc);
        at_cyc = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.done) begin
                at_cyc = cyc;
                break;
            end
        end
        total++;
        if (at_cyc < 0) begin
            bad++;
            $display("FAIL done_timeout: got no done in 200 cycles required done");
        end
    endtask

    int d1, d2, ds;
    logic [511:0] rb;
    logic [255:0] rh;

    initial begin
        bus.start    = 1'b0;
        bus.block_in = '0;
        bus.hash_in  = '0;

        vecs[0] = '{BLK_ABC,   IV, DIG_ABC};
        vecs[1] = '{BLK_EMPTY, IV, DIG_EMPTY};
        for (int i = 2; i < 4; i++) begin
            vecs[i].blk = rand512();
            vecs[i].hv  = rand256();
            vecs[i].dig = ref_compress(vecs[i].blk, vecs[i].hv);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready",    256'(bus.ready), 256'(1));
        check("rst_busy",     256'(bus.busy),  256'(0));
        check("rst_done",     256'(bus.done),  256'(0));
        check("rst_hash_out", bus.hash_out,    256'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            launch(vecs[i].blk, vecs[i].hv);
            check("vec_busy", 256'(bus.busy), 256'(1));
            wait_done(d1);
            check("vec_digest", bus.hash_out, vecs[i].dig);
            check("vec_ready_in_done", 256'(bus.ready), 256'(1));
            @(negedge clk);
            check("vec_done_pulse", 256'(bus.done), 256'(0));
            check("vec_hold", bus.hash_out, vecs[i].dig);
        end

        // Back-to-back: start stays high across the first done cycle.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.block_in = BLK_EMPTY; bus.hash_in = IV;
        @(posedge clk); #1;
        bus.block_in = BLK_ABC;
        wait_done(d1);
        check("b2b_first", bus.hash_out, DIG_EMPTY);
        @(posedge clk); #1 bus.start = 1'b0;
        wait_done(d2);
        check("b2b_gap", 256'(d2 - d1), 256'(66));
        check("b2b_second", bus.hash_out, DIG_ABC);

        // Start pulsed during round t=10 must be ignored.
        launch(BLK_ABC, IV);
        repeat (10) @(posedge clk);
        #1 bus.start = 1'b1; bus.block_in = rand512(); bus.hash_in = rand256();
        @(posedge clk); #1 bus.start = 1'b0;
        wait_done(d1);
        check("ignore_start_digest", bus.hash_out, DIG_ABC);

        // Reset during round t=30 aborts with no done.
        launch(BLK_EMPTY, IV);
        repeat (30) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy",     256'(bus.busy),  256'(0));
        check("abort_ready",    256'(bus.ready), 256'(1));
        check("abort_hash_out", bus.hash_out,    256'h0);
        ds = done_seen;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (80) @(negedge clk);
        check("abort_no_done",   256'(done_seen), 256'(ds));
        check("abort_hash_hold", bus.hash_out,    256'h0);
        launch(BLK_ABC, IV);
        wait_done(d1);
        check("post_abort_digest", bus.hash_out, DIG_ABC);

        // Inputs scrambled every cycle after acceptance.
        for (int r = 0; r < 2; r++) begin
            rb = rand512();
            rh = rand256();
            launch(rb, rh);
            bus.block_in = rand512();
            bus.hash_in  = rand256();
            scramble = 1'b1;
            wait_done(d1);
            scramble = 1'b0;
            check("scramble_digest", bus.hash_out, ref_compress(rb, rh));
        end

        repeat (3) @(posedge clk);
        check("sb_drained", 256'(sb_q.size()), 256'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
